// File: rtl/rvc_asap_pkg.sv
// Shared definitions for the RVC ASAP 5-stage memory access path:
// load/store width encodings, byte-lane size masks and the split FSM states.
package rvc_asap_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic {
        StIdle   = 1'b0,
        StSecond = 1'b1
    } t_state;

    // Unsupported encodings return an empty mask, which suppresses the access.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return MASK_B;
            F3_H, F3_HU: return MASK_H;
            F3_W:        return MASK_W;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/rvc_asap_5pl_load_align.sv
// Load alignment: shifts a 64-bit two-word window right by the byte offset and
// applies the sign/zero extension selected by funct3.
module rvc_asap_5pl_load_align
    import rvc_asap_pkg::*;
(
    input  logic [63:0] i_window,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;

    assign w_shifted = 32'(i_window >> {i_offset, 3'b000});

    always_comb begin
        o_result = w_shifted;
        case (i_funct3)
            F3_B:    o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_result = {24'h000000, w_shifted[7:0]};
            F3_H:    o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_result = {16'h0000, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/rvc_asap_5pl_mem_access.sv
// Memory-stage access unit: byte-lane steering for loads/stores, hardware split
// of word-crossing accesses into two cycles, and Q104H load alignment.
`ifndef RVC_MSFF
`define RVC_MSFF(q, d, clk, rst) \
    always_ff @(posedge clk or posedge rst) begin \
        if (rst) q <= '0; \
        else     q <= d; \
    end
`endif

`ifndef RVC_EN_MSFF
`define RVC_EN_MSFF(q, d, en, clk, rst) \
    always_ff @(posedge clk or posedge rst) begin \
        if (rst)     q <= '0; \
        else if (en) q <= d; \
    end
`endif

module rvc_asap_5pl_mem_access
    import rvc_asap_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] CoreAddrQ103H,
    input  logic [31:0] CoreWrDataQ103H,
    input  logic [2:0]  CoreFunct3Q103H,
    input  logic        CoreWrEnQ103H,
    input  logic        CoreRdEnQ103H,
    output logic [31:0] data,
    output logic [31:0] address,
    output logic [3:0]  byteena,
    output logic        wren,
    output logic        rden,
    input  logic [31:0] q,
    output logic        StallQ103H,
    output logic [31:0] LoadDataQ104H,
    output logic        LoadValidQ104H,
    output logic        MisalignedQ104H
);

    t_state      r_state, w_state_nxt;
    logic [29:0] r_addr;
    logic [31:0] r_data;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic        r_wr, r_rd;
    logic [3:0]  r_be_hi;
    logic [31:0] r_q_first;
    logic        r_ld_valid;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_offset;
    logic        r_ld_split;
    logic [31:0] r_load_data;
    logic        r_mis;

    logic [1:0]  w_offset;
    logic [3:0]  w_mask;
    logic [7:0]  w_be8;
    logic        w_is_wr, w_is_rd, w_cross;
    logic [31:0] w_rot;
    logic        w_capture, w_ld_issue, w_ld_split, w_mis_nxt;
    logic [2:0]  w_ld_funct3;
    logic [1:0]  w_ld_offset;
    logic [63:0] w_window;
    logic [31:0] w_load_result;

    assign w_offset = CoreAddrQ103H[1:0];
    assign w_mask   = size_mask(CoreFunct3Q103H);
    assign w_be8    = {4'b0000, w_mask} << w_offset;
    assign w_is_wr  = CoreWrEnQ103H & (|w_mask);
    assign w_is_rd  = CoreRdEnQ103H & ~CoreWrEnQ103H & (|w_mask);
    // Any lane pushed past byte 3 means the access touches the next word.
    assign w_cross  = |w_be8[7:4];

    always_comb begin
        case (w_offset)
            2'd1:    w_rot = {CoreWrDataQ103H[23:0], CoreWrDataQ103H[31:24]};
            2'd2:    w_rot = {CoreWrDataQ103H[15:0], CoreWrDataQ103H[31:16]};
            2'd3:    w_rot = {CoreWrDataQ103H[7:0],  CoreWrDataQ103H[31:8]};
            default: w_rot = CoreWrDataQ103H;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        address     = {CoreAddrQ103H[31:2], 2'b00};
        byteena     = w_be8[3:0];
        data        = w_rot;
        wren        = 1'b0;
        rden        = 1'b0;
        StallQ103H  = 1'b0;
        w_capture   = 1'b0;
        w_ld_issue  = 1'b0;
        w_ld_funct3 = CoreFunct3Q103H;
        w_ld_offset = w_offset;
        w_ld_split  = 1'b0;
        w_mis_nxt   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_is_wr || w_is_rd) begin
                    if (!w_cross) begin
                        wren       = w_is_wr;
                        rden       = w_is_rd;
                        w_ld_issue = w_is_rd;
                    end else if (SPLIT_EN) begin
                        wren        = w_is_wr;
                        rden        = w_is_rd;
                        StallQ103H  = 1'b1;
                        w_capture   = 1'b1;
                        w_state_nxt = StSecond;
                    end else begin
                        w_mis_nxt = 1'b1;
                    end
                end
            end
            StSecond: begin
                address     = {r_addr + 30'd1, 2'b00};
                byteena     = r_be_hi;
                data        = r_data;
                wren        = r_wr;
                rden        = r_rd;
                w_ld_issue  = r_rd;
                w_ld_funct3 = r_funct3;
                w_ld_offset = r_offset;
                w_ld_split  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
        if (Rst) begin
            wren       = 1'b0;
            rden       = 1'b0;
            StallQ103H = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) r_state <= StIdle;
        else     r_state <= w_state_nxt;
    end

    `RVC_EN_MSFF(r_addr,   CoreAddrQ103H[31:2], w_capture, Clock, Rst)
    `RVC_EN_MSFF(r_data,   w_rot,               w_capture, Clock, Rst)
    `RVC_EN_MSFF(r_funct3, CoreFunct3Q103H,     w_capture, Clock, Rst)
    `RVC_EN_MSFF(r_offset, w_offset,            w_capture, Clock, Rst)
    `RVC_EN_MSFF(r_wr,     w_is_wr,             w_capture, Clock, Rst)
    `RVC_EN_MSFF(r_rd,     w_is_rd,             w_capture, Clock, Rst)
    `RVC_EN_MSFF(r_be_hi,  w_be8[7:4],          w_capture, Clock, Rst)

    // q during the second-part cycle carries the first part's read data.
    `RVC_EN_MSFF(r_q_first,   q,           (r_state == StSecond), Clock, Rst)
    `RVC_MSFF(r_ld_valid,     w_ld_issue,                         Clock, Rst)
    `RVC_EN_MSFF(r_ld_funct3, w_ld_funct3, w_ld_issue,            Clock, Rst)
    `RVC_EN_MSFF(r_ld_offset, w_ld_offset, w_ld_issue,            Clock, Rst)
    `RVC_EN_MSFF(r_ld_split,  w_ld_split,  w_ld_issue,            Clock, Rst)
    `RVC_EN_MSFF(r_load_data, w_load_result, r_ld_valid,          Clock, Rst)
    `RVC_MSFF(r_mis,          w_mis_nxt,                          Clock, Rst)

    assign w_window = r_ld_split ? {q, r_q_first} : {32'h0000_0000, q};

    rvc_asap_5pl_load_align u_load_align (
        .i_window (w_window),
        .i_offset (r_ld_offset),
        .i_funct3 (r_ld_funct3),
        .o_result (w_load_result)
    );

    assign LoadValidQ104H  = r_ld_valid;
    assign LoadDataQ104H   = r_ld_valid ? w_load_result : r_load_data;
    assign MisalignedQ104H = r_mis;

endmodule

// File: tb/tb_rvc_asap_5pl_mem_access.sv
// Directed bench for rvc_asap_5pl_mem_access: one split-enabled and one
// split-disabled instance share the core-side stimulus.
module tb_rvc_asap_5pl_mem_access;

    logic        Clock = 1'b0;
    logic        Rst;
    logic [31:0] CoreAddrQ103H, CoreWrDataQ103H, q;
    logic [2:0]  CoreFunct3Q103H;
    logic        CoreWrEnQ103H, CoreRdEnQ103H;

    logic [31:0] data, address, LoadDataQ104H;
    logic [3:0]  byteena;
    logic        wren, rden, StallQ103H, LoadValidQ104H, MisalignedQ104H;

    logic [31:0] data_ns, address_ns, LoadDataQ104H_ns;
    logic [3:0]  byteena_ns;
    logic        wren_ns, rden_ns, StallQ103H_ns, LoadValidQ104H_ns, MisalignedQ104H_ns;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    rvc_asap_5pl_mem_access u_dut (
        .Clock           (Clock),
        .Rst             (Rst),
        .CoreAddrQ103H   (CoreAddrQ103H),
        .CoreWrDataQ103H (CoreWrDataQ103H),
        .CoreFunct3Q103H (CoreFunct3Q103H),
        .CoreWrEnQ103H   (CoreWrEnQ103H),
        .CoreRdEnQ103H   (CoreRdEnQ103H),
        .data            (data),
        .address         (address),
        .byteena         (byteena),
        .wren            (wren),
        .rden            (rden),
        .q               (q),
        .StallQ103H      (StallQ103H),
        .LoadDataQ104H   (LoadDataQ104H),
        .LoadValidQ104H  (LoadValidQ104H),
        .MisalignedQ104H (MisalignedQ104H)
    );

    rvc_asap_5pl_mem_access #(.SPLIT_EN(1'b0)) u_dut_ns (
        .Clock           (Clock),
        .Rst             (Rst),
        .CoreAddrQ103H   (CoreAddrQ103H),
        .CoreWrDataQ103H (CoreWrDataQ103H),
        .CoreFunct3Q103H (CoreFunct3Q103H),
        .CoreWrEnQ103H   (CoreWrEnQ103H),
        .CoreRdEnQ103H   (CoreRdEnQ103H),
        .data            (data_ns),
        .address         (address_ns),
        .byteena         (byteena_ns),
        .wren            (wren_ns),
        .rden            (rden_ns),
        .q               (q),
        .StallQ103H      (StallQ103H_ns),
        .LoadDataQ104H   (LoadDataQ104H_ns),
        .LoadValidQ104H  (LoadValidQ104H_ns),
        .MisalignedQ104H (MisalignedQ104H_ns)
    );

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic we, input logic re);
        CoreAddrQ103H   = a;
        CoreWrDataQ103H = d;
        CoreFunct3Q103H = f3;
        CoreWrEnQ103H   = we;
        CoreRdEnQ103H   = re;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        q   = 32'h0;
        drive(32'h0000_1001, 32'h0, 3'b010, 1'b0, 1'b1);
        @(negedge Clock); #1;
        n_chk++; if (rden !== 1'b0) begin n_err++; $display("FAIL rst_rden: got %b want 0", rden); end
        n_chk++; if (wren !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b want 0", wren); end
        n_chk++; if (StallQ103H !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", StallQ103H); end
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", LoadValidQ104H); end
        n_chk++; if (LoadDataQ104H !== 32'h0) begin n_err++; $display("FAIL rst_ldata: got %h want 0", LoadDataQ104H); end
        n_chk++; if (MisalignedQ104H_ns !== 1'b0) begin n_err++; $display("FAIL rst_mis: got %b want 0", MisalignedQ104H_ns); end
        @(negedge Clock);
        Rst = 1'b0;
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_lb();
        @(negedge Clock);
        drive(32'h0000_1003, 32'h0, 3'b000, 1'b0, 1'b1);
        #1;
        n_chk++; if (rden !== 1'b1) begin n_err++; $display("FAIL lb_rden: got %b want 1", rden); end
        n_chk++; if (byteena !== 4'b1000) begin n_err++; $display("FAIL lb_be: got %b want 1000", byteena); end
        n_chk++; if (address !== 32'h0000_1000) begin n_err++; $display("FAIL lb_addr: got %h want 00001000", address); end
        n_chk++; if (StallQ103H !== 1'b0) begin n_err++; $display("FAIL lb_stall: got %b want 0", StallQ103H); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        q = 32'h80FF_0000;
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b1) begin n_err++; $display("FAIL lb_valid: got %b want 1", LoadValidQ104H); end
        n_chk++; if (LoadDataQ104H !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", LoadDataQ104H); end
        @(negedge Clock);
        q = 32'h1234_5678;
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL lb_strobe_end: got %b want 0", LoadValidQ104H); end
        n_chk++; if (LoadDataQ104H !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_hold: got %h want ffffff80", LoadDataQ104H); end
    endtask

    task automatic test_sw_split();
        @(negedge Clock);
        drive(32'h0000_1002, 32'h1122_3344, 3'b010, 1'b1, 1'b0);
        #1;
        n_chk++; if (address !== 32'h0000_1000) begin n_err++; $display("FAIL sw_addr0: got %h want 00001000", address); end
        n_chk++; if (byteena !== 4'b1100) begin n_err++; $display("FAIL sw_be0: got %b want 1100", byteena); end
        n_chk++; if (data !== 32'h3344_1122) begin n_err++; $display("FAIL sw_data0: got %h want 33441122", data); end
        n_chk++; if (wren !== 1'b1) begin n_err++; $display("FAIL sw_wren0: got %b want 1", wren); end
        n_chk++; if (StallQ103H !== 1'b1) begin n_err++; $display("FAIL sw_stall0: got %b want 1", StallQ103H); end
        @(negedge Clock);
        // Second part must come from captured state, not the current inputs.
        drive(32'h0000_2000, 32'hDEAD_BEEF, 3'b000, 1'b0, 1'b1);
        #1;
        n_chk++; if (address !== 32'h0000_1004) begin n_err++; $display("FAIL sw_addr1: got %h want 00001004", address); end
        n_chk++; if (byteena !== 4'b0011) begin n_err++; $display("FAIL sw_be1: got %b want 0011", byteena); end
        n_chk++; if (data !== 32'h3344_1122) begin n_err++; $display("FAIL sw_data1: got %h want 33441122", data); end
        n_chk++; if (wren !== 1'b1 || rden !== 1'b0) begin n_err++; $display("FAIL sw_kind1: got wren %b rden %b want 1 0", wren, rden); end
        n_chk++; if (StallQ103H !== 1'b0) begin n_err++; $display("FAIL sw_stall1: got %b want 0", StallQ103H); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL sw_novalid: got %b want 0", LoadValidQ104H); end
    endtask

    task automatic test_lhu_split();
        @(negedge Clock);
        drive(32'h0000_1003, 32'h0, 3'b101, 1'b0, 1'b1);
        #1;
        n_chk++; if (rden !== 1'b1 || byteena !== 4'b1000 || StallQ103H !== 1'b1) begin
            n_err++; $display("FAIL lhu_part0: got rden %b be %b stall %b want 1 1000 1", rden, byteena, StallQ103H); end
        @(negedge Clock);
        q = 32'hAB00_0000;
        #1;
        n_chk++; if (rden !== 1'b1 || address !== 32'h0000_1004 || byteena !== 4'b0001) begin
            n_err++; $display("FAIL lhu_part1: got rden %b addr %h be %b want 1 00001004 0001", rden, address, byteena); end
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL lhu_early: got %b want 0", LoadValidQ104H); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        q = 32'h0000_00CD;
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b1) begin n_err++; $display("FAIL lhu_valid: got %b want 1", LoadValidQ104H); end
        n_chk++; if (LoadDataQ104H !== 32'h0000_CDAB) begin n_err++; $display("FAIL lhu_data: got %h want 0000cdab", LoadDataQ104H); end
        @(negedge Clock); #1;
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL lhu_one_strobe: got %b want 0", LoadValidQ104H); end
    endtask

    task automatic test_lw_wrap();
        @(negedge Clock);
        drive(32'hFFFF_FFFE, 32'h0, 3'b010, 1'b0, 1'b1);
        #1;
        n_chk++; if (address !== 32'hFFFF_FFFC || byteena !== 4'b1100) begin
            n_err++; $display("FAIL wrap_part0: got addr %h be %b want fffffffc 1100", address, byteena); end
        @(negedge Clock);
        q = 32'hBBAA_0000;
        #1;
        n_chk++; if (address !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_addr1: got %h want 00000000", address); end
        n_chk++; if (byteena !== 4'b0011) begin n_err++; $display("FAIL wrap_be1: got %b want 0011", byteena); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        q = 32'h0000_DDCC;
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b1 || LoadDataQ104H !== 32'hDDCC_BBAA) begin
            n_err++; $display("FAIL wrap_data: got valid %b data %h want 1 ddccbbaa", LoadValidQ104H, LoadDataQ104H); end
    endtask

    task automatic test_single_mixed();
        // SH at offset 1 stays in one word; both enables high means store only.
        @(negedge Clock);
        drive(32'h0000_1001, 32'h0000_BEEF, 3'b001, 1'b1, 1'b1);
        #1;
        n_chk++; if (byteena !== 4'b0110 || data !== 32'h00BE_EF00) begin
            n_err++; $display("FAIL sh_lanes: got be %b data %h want 0110 00beef00", byteena, data); end
        n_chk++; if (wren !== 1'b1 || rden !== 1'b0 || StallQ103H !== 1'b0) begin
            n_err++; $display("FAIL sh_kind: got wren %b rden %b stall %b want 1 0 0", wren, rden, StallQ103H); end
        @(negedge Clock);
        drive(32'h0000_1002, 32'h0, 3'b001, 1'b0, 1'b1);
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL sh_novalid: got %b want 0", LoadValidQ104H); end
        @(negedge Clock);
        drive(32'h0000_1000, 32'h0, 3'b011, 1'b0, 1'b1);
        q = 32'h8001_0000;
        #1;
        n_chk++; if (LoadDataQ104H !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_sign: got %h want ffff8001", LoadDataQ104H); end
        n_chk++; if (rden !== 1'b0 || wren !== 1'b0 || StallQ103H !== 1'b0) begin
            n_err++; $display("FAIL f3_illegal: got rden %b wren %b stall %b want 0 0 0", rden, wren, StallQ103H); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL f3_novalid: got %b want 0", LoadValidQ104H); end
    endtask

    task automatic test_reset_in_second();
        @(negedge Clock);
        drive(32'h0000_1001, 32'h0, 3'b010, 1'b0, 1'b1);
        #1;
        n_chk++; if (StallQ103H !== 1'b1) begin n_err++; $display("FAIL rs_stall: got %b want 1", StallQ103H); end
        @(negedge Clock);
        Rst = 1'b1;
        #1;
        n_chk++; if (rden !== 1'b0 || wren !== 1'b0 || StallQ103H !== 1'b0) begin
            n_err++; $display("FAIL rs_abandon: got rden %b wren %b stall %b want 0 0 0", rden, wren, StallQ103H); end
        @(negedge Clock);
        Rst = 1'b0;
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b0) begin n_err++; $display("FAIL rs_novalid: got %b want 0", LoadValidQ104H); end
        @(negedge Clock);
        drive(32'h0000_1000, 32'h0, 3'b010, 1'b0, 1'b1);
        #1;
        n_chk++; if (address !== 32'h0000_1000 || byteena !== 4'b1111 || StallQ103H !== 1'b0) begin
            n_err++; $display("FAIL rs_idle: got addr %h be %b stall %b want 00001000 1111 0", address, byteena, StallQ103H); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        q = 32'h1234_5678;
        #1;
        n_chk++; if (LoadValidQ104H !== 1'b1 || LoadDataQ104H !== 32'h1234_5678) begin
            n_err++; $display("FAIL rs_lw: got valid %b data %h want 1 12345678", LoadValidQ104H, LoadDataQ104H); end
    endtask

    task automatic test_misaligned();
        @(negedge Clock);
        drive(32'h0000_1001, 32'h0, 3'b010, 1'b0, 1'b1);
        #1;
        n_chk++; if (rden_ns !== 1'b0 || StallQ103H_ns !== 1'b0) begin
            n_err++; $display("FAIL mis_suppress: got rden %b stall %b want 0 0", rden_ns, StallQ103H_ns); end
        n_chk++; if (rden !== 1'b1 || StallQ103H !== 1'b1) begin
            n_err++; $display("FAIL mis_split_on: got rden %b stall %b want 1 1", rden, StallQ103H); end
        @(negedge Clock);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        #1;
        n_chk++; if (MisalignedQ104H_ns !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b want 1", MisalignedQ104H_ns); end
        n_chk++; if (LoadValidQ104H_ns !== 1'b0) begin n_err++; $display("FAIL mis_novalid: got %b want 0", LoadValidQ104H_ns); end
        n_chk++; if (MisalignedQ104H !== 1'b0) begin n_err++; $display("FAIL mis_split_flag: got %b want 0", MisalignedQ104H); end
        @(negedge Clock); #1;
        n_chk++; if (MisalignedQ104H_ns !== 1'b0) begin n_err++; $display("FAIL mis_one_cycle: got %b want 0", MisalignedQ104H_ns); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sw_split();
        test_lhu_split();
        test_lw_wrap();
        test_single_mixed();
        test_reset_in_second();
        test_misaligned();
        repeat (2) @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
